fft_sequencer: RTL and testbench

FFT_SEQUENCER -- requirements
Module: fft_sequencer

---
 rtl/fft_pkg.sv | 8 +
 rtl/fft_sequencer_if.sv | 30 +++
 rtl/fft_addr_gen.sv | 24 ++
 rtl/fft_sequencer.sv | 129 ++++++++++++
 tb/tb_fft_sequencer.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// fft_pkg: default FFT sizing/latencies and the sequencer FSM state type
package fft_pkg;
    localparam int N_LOG2_DEF       = 10;
    localparam int DATA_WIDTH_DEF   = 24;
    localparam int MEM_LATENCY_DEF  = 1;
    localparam int BFLY_LATENCY_DEF = 3;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
endpackage

// File: rtl/fft_sequencer_if.sv
// fft_sequencer_if: control, RAM address and butterfly handshake bundle of the FFT sequencer
interface fft_sequencer_if
    import fft_pkg::*;
    #(parameter int N_LOG2 = N_LOG2_DEF);
    localparam int SW = $clog2(N_LOG2);
    logic              i_start;
    logic              o_busy;
    logic              o_done;
    logic              o_rd_en;
    logic [N_LOG2-1:0] o_rd_addr_a;
    logic [N_LOG2-1:0] o_rd_addr_b;
    logic [N_LOG2-2:0] o_tw_addr;
    logic              o_bfly_start;
    logic              i_bfly_valid;
    logic              o_wr_en;
    logic [N_LOG2-1:0] o_wr_addr_a;
    logic [N_LOG2-1:0] o_wr_addr_b;
    logic [SW-1:0]     o_stage;
    logic              o_err;
    modport slave (
        input  i_start, i_bfly_valid,
        output o_busy, o_done, o_rd_en, o_rd_addr_a, o_rd_addr_b, o_tw_addr, o_bfly_start,
               o_wr_en, o_wr_addr_a, o_wr_addr_b, o_stage, o_err
    );
    modport master (
        output i_start, i_bfly_valid,
        input  o_busy, o_done, o_rd_en, o_rd_addr_a, o_rd_addr_b, o_tw_addr, o_bfly_start,
               o_wr_en, o_wr_addr_a, o_wr_addr_b, o_stage, o_err
    );
endinterface

// File: rtl/fft_addr_gen.sv
// fft_addr_gen: radix-2 in-place operand pair and twiddle index for stage s, butterfly k
module fft_addr_gen
    import fft_pkg::*;
#(
    parameter int N_LOG2 = N_LOG2_DEF
) (
    input  logic [$clog2(N_LOG2)-1:0] s,
    input  logic [N_LOG2-2:0]         k,
    output logic [N_LOG2-1:0]         addr_a,
    output logic [N_LOG2-1:0]         addr_b,
    output logic [N_LOG2-2:0]         tw
);
    localparam logic [N_LOG2-1:0] ONE = 1;
    logic [N_LOG2-1:0] kk, span, pos;
    // addr_a has a zero in the span bit, so OR-ing span in is the +span
    always_comb begin
        kk     = {1'b0, k};
        span   = ONE << s;
        pos    = kk & (span - ONE);
        addr_a = ((kk >> s) << (int'(s) + 1)) | pos;
        addr_b = addr_a | span;
        tw     = (N_LOG2-1)'(pos << (N_LOG2 - 1 - int'(s)));
    end
endmodule

// File: rtl/fft_sequencer.sv
// fft_sequencer: stage/butterfly scheduler for an in-place radix-2 FFT with delayed write-back
module fft_sequencer
    import fft_pkg::*;
#(
    parameter int N_LOG2       = N_LOG2_DEF,
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int MEM_LATENCY  = MEM_LATENCY_DEF,
    parameter int BFLY_LATENCY = BFLY_LATENCY_DEF
) (
    input logic           clk,
    input logic           reset,
    fft_sequencer_if.slave bus
);
    localparam int SW = $clog2(N_LOG2);
    localparam int D  = MEM_LATENCY + BFLY_LATENCY;
    localparam logic [N_LOG2-2:0] K_LAST = '1;
    localparam logic [N_LOG2-2:0] K_ONE  = 1;
    localparam logic [SW-1:0]     S_LAST = SW'(N_LOG2 - 1);
    localparam logic [SW-1:0]     S_ONE  = 1;
    localparam logic [D-1:0]      TAP    = D'(1) << (D - 1);
    state_t            state, state_next;
    logic [SW-1:0]     s, s_next;
    logic [N_LOG2-2:0] k, k_next;
    logic [N_LOG2-1:0] addr_a, addr_b, rd_a, rd_b;
    logic [N_LOG2-2:0] tw;
    logic              rd_en, pending, err;
    logic [D-1:0]      vld;
    logic [N_LOG2-1:0] dla [D];
    logic [N_LOG2-1:0] dlb [D];

    if (N_LOG2 < 2 || N_LOG2 > 12 || DATA_WIDTH < 1 || D < 1) begin : g_bad_params
        $error("fft_sequencer: unsupported parameter set");
    end

    fft_addr_gen #(.N_LOG2(N_LOG2)) u_addr_gen (
        .s      (s),
        .k      (k),
        .addr_a (addr_a),
        .addr_b (addr_b),
        .tw     (tw)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            s     <= '0;
            k     <= '0;
        end else begin
            state <= state_next;
            s     <= s_next;
            k     <= k_next;
        end
    end

    // the tap entry retires this cycle, so only earlier entries keep DRAIN waiting
    assign pending = |(vld & ~TAP);

    always_comb begin
        state_next = state;
        s_next     = s;
        k_next     = k;
        case (state)
            IDLE: if (bus.i_start) begin
                state_next = ISSUE;
                s_next     = '0;
                k_next     = '0;
            end
            ISSUE: begin
                k_next     = k + K_ONE;
                state_next = (k == K_LAST) ? DRAIN : ISSUE;
            end
            DRAIN: if (!pending) begin
                state_next = (s == S_LAST) ? DONE : ISSUE;
                s_next     = (s == S_LAST) ? s : s + S_ONE;
            end
            DONE: begin
                state_next = IDLE;
                s_next     = '0;
            end
            default: state_next = IDLE;
        endcase
    end

    assign rd_en = state == ISSUE;
    assign rd_a  = rd_en ? addr_a : '0;
    assign rd_b  = rd_en ? addr_b : '0;

    // invalid slots carry zero addresses, so the tap needs no extra gating
    always_ff @(posedge clk) begin
        if (reset) begin
            vld <= '0;
            for (int i = 0; i < D; i++) begin
                dla[i] <= '0;
                dlb[i] <= '0;
            end
        end else begin
            vld[0] <= rd_en;
            dla[0] <= rd_a;
            dlb[0] <= rd_b;
            for (int i = 1; i < D; i++) begin
                vld[i] <= vld[i-1];
                dla[i] <= dla[i-1];
                dlb[i] <= dlb[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        err <= reset ? 1'b0 : err | (vld[D-1] != bus.i_bfly_valid);
    end

    if (MEM_LATENCY == 0) begin : g_bs_direct
        assign bus.o_bfly_start = rd_en;
    end else begin : g_bs_delayed
        assign bus.o_bfly_start = vld[MEM_LATENCY-1];
    end

    assign bus.o_busy      = state == ISSUE || state == DRAIN;
    assign bus.o_done      = state == DONE;
    assign bus.o_rd_en     = rd_en;
    assign bus.o_rd_addr_a = rd_a;
    assign bus.o_rd_addr_b = rd_b;
    assign bus.o_tw_addr   = rd_en ? tw : '0;
    assign bus.o_wr_en     = vld[D-1];
    assign bus.o_wr_addr_a = dla[D-1];
    assign bus.o_wr_addr_b = dlb[D-1];
    assign bus.o_stage     = s;
    assign bus.o_err       = err;
endmodule

// File: tb/tb_fft_sequencer.sv
// tb_fft_sequencer: scoreboard bench for an 8-point sequencer with a 3-cycle butterfly model
module tb_fft_sequencer;
    import fft_pkg::*;
    localparam int NL = 3;

    typedef struct {
        int cyc;
        int a;
        int b;
        int tw;
        int stg;
    } ev_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fft_sequencer_if #(.N_LOG2(NL)) bus ();
    fft_sequencer #(.N_LOG2(NL)) dut (.clk(clk), .reset(reset), .bus(bus));

    int ea  [3][4] = '{'{0, 2, 4, 6}, '{0, 1, 4, 5}, '{0, 1, 2, 3}};
    int eb  [3][4] = '{'{1, 3, 5, 7}, '{2, 3, 6, 7}, '{4, 5, 6, 7}};
    int etw [3][4] = '{'{0, 0, 0, 0}, '{0, 2, 0, 2}, '{0, 1, 2, 3}};

    ev_t rd_q[$], wr_q[$], done_q[$];
    int  checks = 0, errors = 0;
    int  cnt = 0, base = 0;
    bit  kill_en = 0;
    int  kill_cyc = 0;
    logic [2:0] sr;
    logic prev_rd = 1'b0;

    always @(posedge clk) cnt <= cnt + 1;

    // butterfly stand-in: valid three cycles after its start, optionally dropped once
    always @(posedge clk) sr <= reset ? 3'b0 : {sr[1:0], bus.o_bfly_start};
    assign bus.i_bfly_valid = sr[2] && !(kill_en && (cnt - base) == kill_cyc);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        int  rel;
        ev_t e;
        rel = cnt - base;
        chk("bfly_start", bus.o_bfly_start, prev_rd);
        if (bus.o_rd_en) begin
            if (rd_q.size() == 0) chk("rd_unexpected_cycle", rel, -1);
            else begin
                e = rd_q.pop_front();
                chk("rd_cycle", rel, e.cyc);
                chk("rd_addr_a", bus.o_rd_addr_a, e.a);
                chk("rd_addr_b", bus.o_rd_addr_b, e.b);
                chk("tw_addr", bus.o_tw_addr, e.tw);
                chk("stage", bus.o_stage, e.stg);
            end
        end
        if (bus.o_wr_en) begin
            if (wr_q.size() == 0) chk("wr_unexpected_cycle", rel, -1);
            else begin
                e = wr_q.pop_front();
                chk("wr_cycle", rel, e.cyc);
                chk("wr_addr_a", bus.o_wr_addr_a, e.a);
                chk("wr_addr_b", bus.o_wr_addr_b, e.b);
            end
        end
        if (bus.o_done) begin
            if (done_q.size() == 0) chk("done_unexpected_cycle", rel, -1);
            else begin
                e = done_q.pop_front();
                chk("done_cycle", rel, e.cyc);
                chk("done_err", bus.o_err, e.a);
                chk("done_busy", bus.o_busy, 0);
            end
        end
        prev_rd = reset ? 1'b0 : bus.o_rd_en;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_run(input int last_rd, input int last_wr, input bit with_done, input int err);
        for (int s = 0; s < 3; s++)
            for (int k = 0; k < 4; k++) begin
                if (1 + 8 * s + k <= last_rd) rd_q.push_back('{1 + 8 * s + k, ea[s][k], eb[s][k], etw[s][k], s});
                if (5 + 8 * s + k <= last_wr) wr_q.push_back('{5 + 8 * s + k, ea[s][k], eb[s][k], 0, s});
            end
        if (with_done) done_q.push_back('{25, err, 0, 0, 0});
    endtask

    task automatic start_run();
        bus.i_start = 1'b1;
        base = cnt;
        tick();
        bus.i_start = 1'b0;
    endtask

    task automatic wait_to(input int c);
        while (cnt - base < c) tick();
    endtask

    task automatic wait_empty();
        int n = 0;
        while (rd_q.size() + wr_q.size() + done_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        chk("schedule_pending", rd_q.size() + wr_q.size() + done_q.size(), 0);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_busy"}, bus.o_busy, 0);
        chk({tag, "_done"}, bus.o_done, 0);
        chk({tag, "_rd_en"}, bus.o_rd_en, 0);
        chk({tag, "_bfly_start"}, bus.o_bfly_start, 0);
        chk({tag, "_wr_en"}, bus.o_wr_en, 0);
        chk({tag, "_err"}, bus.o_err, 0);
        chk({tag, "_rd_addr_a"}, bus.o_rd_addr_a, 0);
        chk({tag, "_rd_addr_b"}, bus.o_rd_addr_b, 0);
        chk({tag, "_tw_addr"}, bus.o_tw_addr, 0);
        chk({tag, "_wr_addr_a"}, bus.o_wr_addr_a, 0);
        chk({tag, "_wr_addr_b"}, bus.o_wr_addr_b, 0);
        chk({tag, "_stage"}, bus.o_stage, 0);
    endtask

    initial begin
        reset = 1'b1;
        bus.i_start = 1'b0;
        repeat (3) tick();
        check_idle("reset");
        reset = 1'b0;
        tick();

        push_run(99, 99, 1, 0);
        start_run();
        chk("busy_cycle1", bus.o_busy, 1);
        wait_empty();
        tick();

        push_run(99, 99, 1, 0);
        start_run();
        wait_to(10);
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        wait_empty();
        tick();

        push_run(12, 8, 0, 0);
        start_run();
        wait_to(12);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle("abort");
        repeat (30) tick();
        chk("abort_leftover", rd_q.size() + wr_q.size(), 0);

        push_run(99, 99, 1, 0);
        start_run();
        wait_empty();
        tick();

        push_run(99, 99, 1, 1);
        kill_en = 1;
        kill_cyc = 6;
        start_run();
        wait_to(6);
        chk("err_cycle6", bus.o_err, 0);
        tick();
        chk("err_cycle7", bus.o_err, 1);
        wait_to(20);
        chk("err_cycle20", bus.o_err, 1);
        wait_empty();
        kill_en = 0;
        repeat (3) tick();
        chk("err_sticky_idle", bus.o_err, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("err_cleared", bus.o_err, 0);
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
